// File: rtl/secure_port_receiver.sv
// secure_port_receiver: Hamming(7,4) single-error-correcting receiver with a two-stage pipeline and a credit-controlled FWFT FIFO
`timescale 1ns/1ps
module secure_port_receiver #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [0:6]       code_in,
  input  logic             code_valid,
  output logic             code_ready,
  output logic [0:3]       data_out,
  output logic             data_valid,
  input  logic             rd_en,
  output logic [CNT_W-1:0] corr_count,
  output logic [2:0]       last_syndrome
);
  localparam int PW = $clog2(FIFO_DEPTH);
  logic [0:6]    s1_code;
  logic [2:0]    s1_syn;
  logic          s1_v;
  logic [0:3]    s2_data;
  logic          s2_v;
  logic [0:3]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   fifo_count;
  logic          up;
  logic [2:0]    syn;
  logic [0:6]    fixed;
  logic [PW+1:0] used;
  logic          take, pop;
  // syndrome of the incoming word and bit-flip correction of the stage-1 word
  always_comb begin
    syn[0] = code_in[0] ^ code_in[2] ^ code_in[4] ^ code_in[6];
    syn[1] = code_in[1] ^ code_in[2] ^ code_in[5] ^ code_in[6];
    syn[2] = code_in[3] ^ code_in[4] ^ code_in[5] ^ code_in[6];
    for (int i = 0; i < 7; i++) fixed[i] = s1_code[i] ^ (s1_syn == 3'(i + 1));
  end
  // credits cover every word already inside the block, so the pipeline never stalls
  assign used       = (PW+2)'(fifo_count) + (PW+2)'(s1_v) + (PW+2)'(s2_v);
  assign code_ready = up && (used < (PW+2)'(FIFO_DEPTH));
  assign take       = code_valid && code_ready;
  assign data_valid = fifo_count != '0;
  assign pop        = rd_en && data_valid;
  assign data_out   = data_valid ? mem[rd_ptr] : 4'b0000;
  // holds code_ready low until the first edge after reset release
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) up <= 1'b0;
    else up <= 1'b1;
  // stage 1: capture the accepted word and its syndrome
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1_v    <= 1'b0;
      s1_code <= '0;
      s1_syn  <= '0;
    end else begin
      s1_v <= take;
      if (take) begin
        s1_code <= code_in;
        s1_syn  <= syn;
      end
    end
  // stage 2: corrected nibble, syndrome report and saturating correction count
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s2_v          <= 1'b0;
      s2_data       <= '0;
      last_syndrome <= '0;
      corr_count    <= '0;
    end else begin
      s2_v <= s1_v;
      if (s1_v) begin
        s2_data       <= {fixed[2], fixed[4], fixed[5], fixed[6]};
        last_syndrome <= s1_syn;
        if (s1_syn != 3'd0 && corr_count != '1) corr_count <= corr_count + CNT_W'(1);
      end
    end
  // FIFO pointers wrap naturally because the depth is a power of two
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (s2_v) wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      fifo_count <= fifo_count + (PW+1)'(s2_v) - (PW+1)'(pop);
    end
  // FIFO storage; contents are masked by data_valid so no reset is needed
  always_ff @(posedge clk)
    if (s2_v) mem[wr_ptr] <= s2_data;
endmodule

// File: tb/tb_secure_port_receiver.sv
// tb_secure_port_receiver: table vectors plus scoreboard-checked streaming, back-pressure, saturation and reset
`timescale 1ns/1ps
module tb_secure_port_receiver;
  typedef struct {
    logic [0:6] code;
    logic [0:3] data;
    logic [2:0] syn;
  } vec_t;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [0:6] code_in = '0;
  logic       code_valid = 1'b0;
  logic       code_ready;
  logic [0:3] data_out;
  logic       data_valid;
  logic       rd_en = 1'b0;
  logic [7:0] corr_count;
  logic [2:0] last_syndrome;
  logic [0:3] exp_in = '0;
  logic [0:3] q[$];
  int         total = 0;
  int         bad = 0;
  int         max_cnt = 0;
  bit         mon = 1'b0;
  secure_port_receiver #(.FIFO_DEPTH(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .code_in(code_in), .code_valid(code_valid),
    .code_ready(code_ready), .data_out(data_out), .data_valid(data_valid),
    .rd_en(rd_en), .corr_count(corr_count), .last_syndrome(last_syndrome)
  );
  always #5 clk = ~clk;
  function automatic logic [0:6] enc(input logic [0:3] d);
    enc = {d[0] ^ d[1] ^ d[3], d[0] ^ d[2] ^ d[3], d[0], d[1] ^ d[2] ^ d[3], d[1], d[2], d[3]};
  endfunction
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  // scoreboard: push on accepted word, pop and compare on effective read
  always @(negedge clk)
    if (rst_n) begin
      if (code_valid && code_ready) q.push_back(exp_in);
      if (rd_en && data_valid) begin
        if (q.size() == 0) chk("sb_unexpected_pop", 1, 0);
        else chk("sb_data", int'(data_out), int'(q.pop_front()));
      end
      if (mon && int'(dut.fifo_count) > max_cnt) max_cnt = int'(dut.fifo_count);
    end
  task automatic stream(input int n, input int every, output int errs);
    int i = 0;
    int guard = 0;
    bit e;
    logic [0:3] nib;
    logic [0:6] cw;
    errs = 0;
    rd_en = 1'b1;
    code_valid = 1'b1;
    while (i < n && guard < n * 4 + 50) begin
      nib = 4'($urandom_range(15));
      cw = enc(nib);
      e = every > 0 && (i % every) == 0;
      if (e) cw[i % 7] = ~cw[i % 7];
      code_in = cw;
      exp_in = nib;
      @(negedge clk);
      if (code_ready) begin
        i++;
        if (e) errs++;
      end
      step();
      guard++;
    end
    code_valid = 1'b0;
    chk("stream_accepted", i, n);
    guard = 0;
    while ((q.size() != 0 || data_valid) && guard < 50) begin
      step();
      guard++;
    end
    rd_en = 1'b0;
    chk("stream_drained", q.size(), 0);
  endtask
  initial begin
    #300000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    vec_t tv[12];
    logic [0:6] c;
    int exp_cc = 0;
    int k = 0;
    int errs = 0;
    tv[0] = '{7'b0110011, 4'b1011, 3'd0};
    tv[1] = '{7'b0110111, 4'b1011, 3'd5};
    for (int p = 1; p <= 7; p++) begin
      c = '0;
      c[p-1] = 1'b1;
      tv[p+1] = '{c, 4'b0000, 3'(p)};
    end
    tv[9] = '{enc(4'b1111), 4'b1111, 3'd0};
    c = enc(4'b0101);
    c[2] = ~c[2];
    tv[10] = '{c, 4'b0101, 3'd3};
    c = enc(4'b1000);
    c[6] = ~c[6];
    tv[11] = '{c, 4'b1000, 3'd7};
    #12;
    chk("rst_ready", code_ready, 0);
    chk("rst_dv", data_valid, 0);
    chk("rst_data", int'(data_out), 0);
    chk("rst_cc", corr_count, 0);
    chk("rst_syn", last_syndrome, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("ready_before_edge", code_ready, 0);
    step();
    chk("ready_after_edge", code_ready, 1);
    for (int i = 0; i < 12; i++) begin
      code_in = tv[i].code;
      exp_in = tv[i].data;
      code_valid = 1'b1;
      step();
      code_valid = 1'b0;
      if (tv[i].syn != 3'd0) exp_cc++;
      chk("lat_edge1_dv", data_valid, 0);
      step();
      chk("lat_edge2_dv", data_valid, 0);
      step();
      chk("vec_dv", data_valid, 1);
      chk("vec_data", int'(data_out), int'(tv[i].data));
      chk("vec_syn", last_syndrome, tv[i].syn);
      chk("vec_cc", corr_count, exp_cc);
      rd_en = 1'b1;
      step();
      rd_en = 1'b0;
      chk("vec_empty", data_valid, 0);
    end
    code_valid = 1'b1;
    for (int cyc = 0; cyc < 10; cyc++) begin
      code_in = enc(4'(k % 4 * 3 + 1));
      exp_in = 4'(k % 4 * 3 + 1);
      @(negedge clk);
      if (code_ready) k++;
      step();
    end
    code_valid = 1'b0;
    chk("bp_accepted", k, 4);
    chk("bp_ready_low", code_ready, 0);
    chk("bp_dv", data_valid, 1);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chk("bp_ready_after_pop", code_ready, 1);
    rd_en = 1'b1;
    for (int i = 0; i < 3; i++) step();
    rd_en = 1'b0;
    chk("bp_drained_dv", data_valid, 0);
    chk("bp_queue", q.size(), 0);
    max_cnt = 0;
    mon = 1'b1;
    stream(20, 3, errs);
    mon = 1'b0;
    chk("stream_max_count_le2", int'(max_cnt <= 2), 1);
    chk("stream_cc", corr_count, exp_cc + errs);
    code_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      code_in = enc(4'(i + 5));
      exp_in = 4'(i + 5);
      step();
    end
    code_valid = 1'b0;
    step();
    step();
    step();
    chk("mid_buffered_dv", data_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_dv", data_valid, 0);
    chk("async_cc", corr_count, 0);
    chk("async_ready", code_ready, 0);
    chk("async_data", int'(data_out), 0);
    q.delete();
    step();
    @(negedge clk);
    rst_n = 1'b1;
    rd_en = 1'b1;
    step();
    chk("rerst_ready", code_ready, 1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("no_stale_dv", data_valid, 0);
    end
    rd_en = 1'b0;
    code_in = 7'b0110011;
    exp_in = 4'b1011;
    code_valid = 1'b1;
    step();
    code_valid = 1'b0;
    step();
    step();
    chk("post_rst_data", int'(data_out), 11);
    chk("post_rst_cc", corr_count, 0);
    chk("post_rst_syn", last_syndrome, 0);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    stream(300, 1, errs);
    chk("sat_errs", errs, 300);
    chk("sat_cc", corr_count, 255);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
